// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes and registers one ALU operation, captures the external ALU's result
// and hands it downstream through a valid/ready handshake (IDLE -> EXEC -> HOLD).
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic             in_src_imm,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [15:0]      in_imm,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [2:0]       sel_q, sel_d, dec_sel;
    logic             ill_q, ill_d, zero_q, zero_d, oill_q, oill_d;
    logic             dec_ill, accept;
    logic [WIDTH-1:0] imm_ext;

    assign in_ready    = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign accept      = in_valid && in_ready;
    assign imm_ext     = {{(WIDTH-16){in_imm[15]}}, in_imm};
    assign out_valid   = state_q == HOLD;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_sel     = sel_q;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = oill_q;

    always_comb begin
        dec_sel = 3'b000;
        dec_ill = 1'b0;
        case (in_aluop)
            2'b00: dec_sel = 3'b010;
            2'b01: dec_sel = 3'b110;
            2'b10: begin
                case (in_funct)
                    6'b100000: dec_sel = 3'b010;
                    6'b100010: dec_sel = 3'b110;
                    6'b100100: dec_sel = 3'b000;
                    6'b100101: dec_sel = 3'b001;
                    6'b101010: dec_sel = 3'b111;
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        ill_d   = ill_q;
        res_d   = res_q;
        zero_d  = zero_q;
        oill_d  = oill_q;
        case (state_q)
            IDLE: state_d = accept ? EXEC : IDLE;
            EXEC: begin
                res_d   = ill_q ? '0 : alu_result;
                zero_d  = res_d == '0;
                oill_d  = ill_q;
                state_d = HOLD;
            end
            HOLD: state_d = out_ready ? (in_valid ? EXEC : IDLE) : HOLD;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            op1_d = in_a;
            op2_d = in_src_imm ? imm_ext : in_b;
            sel_d = dec_sel;
            ill_d = dec_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= 3'b000;
            ill_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            oill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            oill_q  <= oill_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table vectors, random ops against a reference model, and handshake/reset sequences.
module tb_alu_issue_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_src_imm = 1'b0, out_valid, out_ready = 1'b0;
    logic [1:0]  in_aluop = 2'b00;
    logic [5:0]  in_funct = 6'b0;
    logic [31:0] in_a = '0, in_b = '0, alu_op1, alu_op2, alu_result, out_result;
    logic [15:0] in_imm = '0;
    logic [2:0]  alu_sel;
    logic        out_zero, out_illegal;
    int          n_chk = 0, n_fail = 0;

    typedef struct packed {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        src;
        logic [31:0] a, b;
        logic [15:0] imm;
        logic [31:0] op2;
        logic [2:0]  sel;
        logic [31:0] res;
        logic        zero, ill;
    } vec_t;

    vec_t tv[11];

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_src_imm(in_src_imm),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // External ALU seen by the stage.
    always_comb begin
        case (alu_sel)
            3'b010:  alu_result = alu_op1 + alu_op2;
            3'b110:  alu_result = alu_op1 - alu_op2;
            3'b000:  alu_result = alu_op1 & alu_op2;
            3'b001:  alu_result = alu_op1 | alu_op2;
            3'b111:  alu_result = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] aluop, input logic [5:0] funct, input logic src,
                                   input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
        vec_t v;
        int   sa, sb;
        v = '0;
        v.aluop = aluop; v.funct = funct; v.src = src; v.a = a; v.b = b; v.imm = imm;
        v.op2 = src ? 32'($signed(imm)) : b;
        sa = $signed(a);
        sb = $signed(v.op2);
        v.ill = 1'b0;
        if (aluop == 2'd0) begin v.sel = 3'b010; v.res = a + v.op2; end
        else if (aluop == 2'd1) begin v.sel = 3'b110; v.res = a - v.op2; end
        else if (aluop == 2'd2 && funct == 6'd32) begin v.sel = 3'b010; v.res = a + v.op2; end
        else if (aluop == 2'd2 && funct == 6'd34) begin v.sel = 3'b110; v.res = a - v.op2; end
        else if (aluop == 2'd2 && funct == 6'd36) begin v.sel = 3'b000; v.res = a & v.op2; end
        else if (aluop == 2'd2 && funct == 6'd37) begin v.sel = 3'b001; v.res = a | v.op2; end
        else if (aluop == 2'd2 && funct == 6'd42) begin v.sel = 3'b111; v.res = (sa < sb) ? 1 : 0; end
        else begin v.sel = 3'b000; v.res = 0; v.ill = 1'b1; end
        v.zero = v.res == 0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_aluop = v.aluop; in_funct = v.funct; in_src_imm = v.src;
        in_a = v.a; in_b = v.b; in_imm = v.imm; in_valid = 1'b1;
    endtask

    // Called at a negedge; waits for acceptance and checks the op through HOLD.
    task automatic do_op(input vec_t v, input string tag);
        int budget = 0;
        drive(v);
        out_ready = 1'b1;
        while (!in_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, " accept_timeout"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " exec_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " op1"}, alu_op1, v.a);
        chk({tag, " op2"}, alu_op2, v.op2);
        chk({tag, " sel"}, {29'b0, alu_sel}, {29'b0, v.sel});
        @(negedge clk);
        chk({tag, " hold_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, " result"}, out_result, v.res);
        chk({tag, " zero"}, {31'b0, out_zero}, {31'b0, v.zero});
        chk({tag, " illegal"}, {31'b0, out_illegal}, {31'b0, v.ill});
    endtask

    initial begin
        vec_t v;
        logic [31:0] held_res, held_op1;
        logic [5:0] legal[5];
        legal[0] = 6'd32; legal[1] = 6'd34; legal[2] = 6'd36; legal[3] = 6'd37; legal[4] = 6'd42;

        //            aluop  funct      src a             b             imm       op2           sel     res           z     ill
        tv[0]  = '{2'b10, 6'b100000, 1'b0, 32'd3,        32'd2,        16'h0,    32'd2,        3'b010, 32'd5,        1'b0, 1'b0};
        tv[1]  = '{2'b01, 6'b000000, 1'b1, 32'd7,        32'd99,       16'h0007, 32'd7,        3'b110, 32'd0,        1'b1, 1'b0};
        tv[2]  = '{2'b00, 6'b000000, 1'b1, 32'd1,        32'd5,        16'hFFFF, 32'hFFFFFFFF, 3'b010, 32'd0,        1'b1, 1'b0};
        tv[3]  = '{2'b10, 6'b101010, 1'b0, 32'd2,        32'd9,        16'h0,    32'd9,        3'b111, 32'd1,        1'b0, 1'b0};
        tv[4]  = '{2'b10, 6'b111111, 1'b0, 32'd5,        32'd6,        16'h0,    32'd6,        3'b000, 32'd0,        1'b1, 1'b1};
        tv[5]  = '{2'b11, 6'b100000, 1'b0, 32'd8,        32'd8,        16'h0,    32'd8,        3'b000, 32'd0,        1'b1, 1'b1};
        tv[6]  = '{2'b10, 6'b100100, 1'b0, 32'h0000F0F0, 32'h0000FF00, 16'h0,    32'h0000FF00, 3'b000, 32'h0000F000, 1'b0, 1'b0};
        tv[7]  = '{2'b10, 6'b100101, 1'b0, 32'h0000F0F0, 32'h00000F0F, 16'h0,    32'h00000F0F, 3'b001, 32'h0000FFFF, 1'b0, 1'b0};
        tv[8]  = '{2'b10, 6'b100010, 1'b0, 32'd5,        32'd9,        16'h0,    32'd9,        3'b110, 32'hFFFFFFFC, 1'b0, 1'b0};
        tv[9]  = '{2'b10, 6'b101010, 1'b0, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd1,        3'b111, 32'd1,        1'b0, 1'b0};
        tv[10] = '{2'b00, 6'b000000, 1'b1, 32'd0,        32'd3,        16'h8000, 32'hFFFF8000, 3'b010, 32'hFFFF8000, 1'b0, 1'b0};

        #2;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", out_result, 32'd0);
        chk("reset_ops", alu_op1 | alu_op2 | {29'b0, alu_sel}, 32'd0);
        chk("reset_flags", {30'b0, out_zero, out_illegal}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) do_op(tv[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)];
            v = model(op, fn, 1'($urandom), $urandom, $urandom, 16'($urandom));
            do_op(v, $sformatf("rnd%0d", i));
        end

        // Back-pressure: result held while downstream stalls, next op queued upstream.
        v = model(2'b10, 6'd32, 1'b0, 32'd10, 32'd20, 16'h0);
        do_op(v, "bp_first");
        out_ready = 1'b0;
        drive(model(2'b01, 6'd0, 1'b0, 32'd50, 32'd8, 16'h0));
        held_res = out_result;
        held_op1 = alu_op1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
            chk("bp_valid_high", {31'b0, out_valid}, 32'd1);
            chk("bp_result_stable", out_result, 32'd30);
            chk("bp_op1_stable", alu_op1, held_op1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_exec_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_new_op1", alu_op1, 32'd50);
        @(negedge clk);
        chk("bp_new_result", out_result, 32'd42);
        chk("bp_old_result_seen", held_res, 32'd30);

        // Reset in the middle of EXEC discards the instruction.
        @(negedge clk);
        drive(model(2'b00, 6'd0, 1'b0, 32'd4, 32'd4, 16'h0));
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid_in_exec", alu_op1, 32'd4);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_result", out_result, 32'd0);
        chk("rst_mid_ops", alu_op1 | alu_op2 | {29'b0, alu_sel}, 32'd0);
        chk("rst_mid_flags", {30'b0, out_zero, out_illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_valid", {31'b0, out_valid}, 32'd0);
        end
        do_op(model(2'b10, 6'd37, 1'b1, 32'h00F0, 32'd0, 16'h000F), "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
